// File: rtl/morty_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// morty_sprite_ctrl
//
// Per-pixel sequencer for the character sprite on the VGA path. It takes the
// raster position from the VGA timing block, decides whether the pixel lies
// inside the sprite box and addresses the sprite ROM. A 3-bit color index
// (0 = background) comes out two cycles after the pixel, aligned with
// color_valid. It also holds the sprite position (double-buffered, updated
// only at frame_start) and a two-pose animation sequencer.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   px_valid            hcount/vcount describe a visible pixel this cycle
//   hcount, vcount      raster column / row
//   frame_start         one-cycle pulse at the start of vertical blanking
//   pos_x_req/pos_y_req requested sprite top-left corner
//   pos_we / pos_ready  position request handshake
//   rom_addr            sprite ROM address {pose, row*SPR_W + col}
//   rom_data            ROM color index for the current rom_addr
//   color               color index to the decoder
//   color_valid         color belongs to a visible pixel
//   in_sprite           color comes from an opaque sprite pixel
//   state_dbg           current FSM state (0 = WAIT_FRAME, 1 = RUN)
// -----------------------------------------------------------------------------
module morty_sprite_ctrl #(
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 64,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ANIM_DIV = 15,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              px_valid,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              frame_start,
    input  logic [9:0]        pos_x_req,
    input  logic [9:0]        pos_y_req,
    input  logic              pos_we,
    output logic              pos_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [2:0]        color,
    output logic              color_valid,
    output logic              in_sprite,
    output logic              state_dbg
);

    localparam int PIX_W = ADDR_W - 1;
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_W);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPR_H);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Position registers: cur_* is what the raster uses, shadow_* holds one
    // pending request until the next frame_start.
    logic [9:0] cur_x, cur_y;
    logic [9:0] shadow_x, shadow_y;
    logic       shadow_full;

    logic       pose;
    logic [7:0] anim_cnt;

    // Stage-1 registers alongside rom_addr.
    logic valid_d, hit_d;

    // Combinational stage-1 terms.
    logic [10:0]       dx, dy;
    logic              in_x, in_y, hit;
    logic [PIX_W-1:0]  pix_off;
    logic [ADDR_W-1:0] addr_next;
    logic              pos_accept;
    logic [9:0]        clamp_x, clamp_y;

    // Handshake: a position request transfers on any rising clk edge where
    // pos_we && pos_ready. pos_ready is high exactly while the shadow register
    // is empty; the requester must hold pos_x_req/pos_y_req/pos_we stable
    // until the transfer happens. Requests while pos_ready=0 are ignored.
    assign pos_ready  = ~shadow_full;
    assign pos_accept = pos_we && pos_ready;
    assign clamp_x    = (pos_x_req > X_MAX) ? X_MAX : pos_x_req;
    assign clamp_y    = (pos_y_req > Y_MAX) ? Y_MAX : pos_y_req;
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (frame_start) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // ------------------------------------------------------- position regs
    // Accept and apply can never coincide: accept needs an empty shadow and
    // apply needs a full one. So a request landing on a frame_start edge
    // only fills the shadow and waits for the following frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x       <= '0;
            cur_y       <= '0;
            shadow_x    <= '0;
            shadow_y    <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (frame_start && shadow_full) begin
                cur_x       <= shadow_x;
                cur_y       <= shadow_y;
                shadow_full <= 1'b0;
            end
            if (pos_accept) begin
                shadow_x    <= clamp_x;
                shadow_y    <= clamp_y;
                shadow_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ animation
    // Counted only on frame_start while already in RUN, so the pose is
    // constant across every visible frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            anim_cnt <= '0;
            pose     <= 1'b0;
        end else if (frame_start && (state_q == RUN)) begin
            if (anim_cnt == ANIM_LAST) begin
                anim_cnt <= '0;
                pose     <= ~pose;
            end else begin
                anim_cnt <= anim_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------ stage 1 compare
    // Offsets are computed one bit wider; the explicit >= tests reject
    // pixels left/above the box so a wrapped difference never counts as a hit.
    always_comb begin
        dx        = {1'b0, hcount} - {1'b0, cur_x};
        dy        = {1'b0, vcount} - {1'b0, cur_y};
        in_x      = (hcount >= cur_x) && (dx < 11'(SPR_W));
        in_y      = (vcount >= cur_y) && (dy < 11'(SPR_H));
        hit       = (state_q == RUN) && px_valid && in_x && in_y;
        pix_off   = PIX_W'(dy) * PIX_W'(SPR_W) + PIX_W'(dx);
        addr_next = hit ? {pose, pix_off} : '0;
    end

    // rom_addr acts as the ROM's address register; the ROM output for it is
    // present on rom_data in the following cycle, when stage 2 captures it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            valid_d  <= 1'b0;
            hit_d    <= 1'b0;
        end else begin
            rom_addr <= addr_next;
            valid_d  <= px_valid;
            hit_d    <= hit;
        end
    end

    // ------------------------------------------------------ stage 2 output
    // Indices 0 and 7 are transparent and fall through to background.
    always_ff @(posedge clk) begin
        if (rst) begin
            color       <= '0;
            color_valid <= 1'b0;
            in_sprite   <= 1'b0;
        end else begin
            color_valid <= valid_d;
            if (hit_d && (rom_data != 3'd0) && (rom_data != 3'd7)) begin
                color     <= rom_data;
                in_sprite <= 1'b1;
            end else begin
                color     <= 3'd0;
                in_sprite <= 1'b0;
            end
        end
    end

endmodule

// File: doc/morty_sprite_ctrl.md
Name: morty_sprite_ctrl

Overview:
Per-pixel sequencer for the character sprite on the VGA path. Takes the raster position from the VGA timing block, decides whether the pixel falls inside the sprite box, and addresses the sprite ROM. It emits a 3-bit color index, pipeline-aligned with the pixel, to the color decoder (index 0 = background).
It also owns sprite position (double-buffered, frame-synchronous update) and a two-pose animation sequencer.

Parameters:
SPR_W, 64, sprite width in pixels (power of 2)
SPR_H, 64, sprite height in pixels
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
ANIM_DIV, 15, video frames per animation pose (1..255)
ADDR_W, 13, ROM address width = log2(SPR_W*SPR_H)+1 (MSB = pose)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
px_valid  in  1  hcount/vcount are a visible pixel this cycle
hcount  in  10  column, 0..H_ACTIVE-1
vcount  in  10  row, 0..V_ACTIVE-1
frame_start  in  1  one-cycle pulse at start of vertical blanking
pos_x_req  in  10  requested sprite left edge
pos_y_req  in  10  requested sprite top edge
pos_we  in  1  position request valid
pos_ready  out  1  shadow register free; request accepted when pos_we && pos_ready
rom_addr  out  ADDR_W  sprite ROM address (sync ROM, 1-cycle read latency)
rom_data  in  3  ROM color index, valid the cycle after rom_addr
color  out  3  color index to the decoder
color_valid  out  1  color corresponds to a visible pixel
in_sprite  out  1  color comes from an opaque sprite pixel

Behaviour:
- Reset values: rom_addr=0, color=0, color_valid=0, in_sprite=0, pos_ready=1. Current pos=(0,0), shadow empty, pose=0, anim counter=0, state=WAIT_FRAME.
- FSM, 2 states:
  - WAIT_FRAME: sprite disabled; every pixel is background. On frame_start go to RUN.
  - RUN: sprite enabled. Stays in RUN until rst. Reset mid-frame returns to WAIT_FRAME on the next edge; the pipeline is flushed to reset values.
- Position handshake:
  - Request accepted on pos_we && pos_ready. Shadow <= clamped request; pos_ready <= 0 next cycle.
  - Clamp: x = min(pos_x_req, H_ACTIVE-SPR_W); y = min(pos_y_req, V_ACTIVE-SPR_H).
  - On frame_start with shadow full: current pos <= shadow, pos_ready <= 1. Applies in both states.
  - Simultaneous frame_start and accepted request with shadow empty: the new value goes to the shadow only and is applied at the next frame_start.
  - pos_we while pos_ready=0 is ignored; the requester holds it.
- Animation: on each frame_start in RUN, anim counter increments. When it reaches ANIM_DIV-1 it wraps to 0 and pose toggles. Pose never changes mid-frame.
- Pipeline, latency 2 from px_valid to color_valid:
  - Stage 1 (registered):
    - hit = RUN && px_valid && hcount-x in [0,SPR_W) && vcount-y in [0,SPR_H), using unsigned compares with no underflow wrap.
    - rom_addr = {pose, (vcount-y)*SPR_W + (hcount-x)} when hit, else 0.
    - Valid and hit are delayed alongside.
  - Stage 2 (registered): color_valid = valid_d. If hit_d and rom_data not in {0,7}: color = rom_data, in_sprite = 1. Otherwise color = 0, in_sprite = 0. Indices 0 and 7 are transparent.
  - px_valid=0 yields color_valid=0 and color=0 two cycles later.
- Boundaries:
  - Box edges: x and x+SPR_W-1 are inside; x+SPR_W is outside. Same for y.
  - Sprite at the clamped maximum fits exactly at the right/bottom edge.
  - No wrap at column 0 when x=0.

Test Plan:
- Reset, then pixels at (0,0)..(5,0) with no frame_start → color_valid follows px_valid at +2 cycles; color=0, in_sprite=0 throughout.
- pos_we (100,50), frame_start, ROM returns 3 → pixel (100,50): rom_addr=0 one cycle later, color=3, in_sprite=1. Pixel (163,113): rom_addr=4095. Pixel (164,50): color=0.
- ROM returns 0 or 7 inside box → color=0, in_sprite=0.
- pos_we (700,470) → clamped to (576,416). pos_ready=0 until frame_start. A second pos_we while pos_ready=0 is not accepted. After frame_start, pixel (639,479) hits with rom_addr=4095.
- frame_start coinciding with pos_we → position unchanged this frame; applied at the following frame_start.
- ANIM_DIV=15, 15 frame_starts in RUN → pose flips; rom_addr MSB=1 for in-box pixels. 30 frame_starts → back to 0. rst mid-frame → outputs return to reset values next cycle.
